// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard (optional REGFILE_MP_BYPASS_EN forwarding)
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic                     flush,
   output logic                     wr_conflict
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;

   // Register array: port 1 overrides port 0 on a shared address; entry 0 stays zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (we1 && wa1 == ADDR_W'(i)) begin
               mem[i] <= wd1;
            end else if (we0 && wa0 == ADDR_W'(i)) begin
               mem[i] <= wd0;
            end
         end
      end
   end

   // Scoreboard: flush beats alloc, alloc beats a completing write to the same register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy[0] <= 1'b0;
         for (int i = 1; i < DEPTH; i++) begin
            if (flush) begin
               busy[i] <= 1'b0;
            end else if (alloc_en && alloc_addr == ADDR_W'(i)) begin
               busy[i] <= 1'b1;
            end else if ((we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i))) begin
               busy[i] <= 1'b0;
            end
         end
      end
   end

   // Conflict flag: both ports wrote the same nonzero register on the previous edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_conflict <= 1'b0;
      end else begin
         wr_conflict <= we0 && we1 && (wa0 == wa1) && (wa0 != '0);
      end
   end

   // Read ports: array lookup, optionally forwarding the in-flight write and its busy clear
   always_comb begin
      rd      = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data;
         logic              bsy;
         addr = ra[k*ADDR_W +: ADDR_W];
         data = mem[addr];
         bsy  = busy[addr];
`ifdef REGFILE_MP_BYPASS_EN
         if (we1 && wa1 == addr) begin
            data = wd1;
         end else if (we0 && wa0 == addr) begin
            data = wd0;
         end
         if (((we1 && wa1 == addr) || (we0 && wa0 == addr)) &&
             !(alloc_en && alloc_addr == addr)) begin
            bsy = 1'b0;
         end
`endif
         if (addr == '0) begin
            data = '0;
            bsy  = 1'b0;
         end
         rd[k*DATA_W +: DATA_W] = data;
         rd_busy[k]             = bsy;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_RD*ADDR_W-1:0] ra;
   logic [NUM_RD*DATA_W-1:0] rd;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     we0, we1, alloc_en, flush;
   logic [ADDR_W-1:0]        wa0, wa1, alloc_addr;
   logic [DATA_W-1:0]        wd0, wd1;
   logic                     wr_conflict;

   int tests_run;
   int tests_failed;

   regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
      .wr_conflict(wr_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0; flush = 1'b0;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic set_ra(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      ra = {a1, a0};
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      idle();
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; alloc_addr = '0;
      ra = '0;
      #12;
      rst_n = 1'b1;
      #1;

      // 1: reset state on every address
      check("reset_conflict", 64'(wr_conflict), 64'd0);
      for (int a = 0; a < (1 << ADDR_W); a++) begin
         set_ra(ADDR_W'(a), ADDR_W'(a));
         #1;
         check($sformatf("reset_rd_%0d", a), rd, 64'd0);
         check($sformatf("reset_busy_%0d", a), 64'(rd_busy), 64'd0);
      end

      // 2: write r5 and read it in the same cycle
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'd11;
      set_ra(5'd5, 5'd5);
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      check("w5_same_cycle", rd, {32'd11, 32'd11});
`else
      check("w5_same_cycle", rd, 64'd0);
`endif
      edge_step();
      check("w5_after_edge", rd, {32'd11, 32'd11});
      edge_step();
      check("w5_hold", rd, {32'd11, 32'd11});

      // 3: both ports write r7, port 1 wins, conflict pulse
      we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
      wd0 = 32'h1111; wd1 = 32'h2222;
      set_ra(5'd7, 5'd0);
      #1;
      check("conflict_before_edge", 64'(wr_conflict), 64'd0);
      edge_step();
      check("conflict_pulse", 64'(wr_conflict), 64'd1);
      check("r7_port1_wins", 64'(rd[31:0]), 64'h2222);
      edge_step();
      check("conflict_cleared", 64'(wr_conflict), 64'd0);

      // 4: r0 ignores writes and allocs
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF;
      alloc_en = 1'b1; alloc_addr = 5'd0;
      set_ra(5'd0, 5'd0);
      #1;
      check("r0_same_cycle", rd, 64'd0);
      edge_step();
      check("r0_after", rd, 64'd0);
      check("r0_busy", 64'(rd_busy), 64'd0);
      check("r0_no_conflict", 64'(wr_conflict), 64'd0);

      // 5: scoreboard set, alloc-beats-write, flush
      alloc_en = 1'b1; alloc_addr = 5'd9;
      set_ra(5'd9, 5'd9);
      edge_step();
      check("r9_busy_set", 64'(rd_busy), 64'd3);
      we1 = 1'b1; wa1 = 5'd9; wd1 = 32'd42;
      alloc_en = 1'b1; alloc_addr = 5'd9;
      #1;
      check("r9_busy_realloc_pre", 64'(rd_busy), 64'd3);
      edge_step();
      check("r9_busy_stays", 64'(rd_busy), 64'd3);
      check("r9_data", rd, {32'd42, 32'd42});
      flush = 1'b1;
      alloc_en = 1'b1; alloc_addr = 5'd10;
      set_ra(5'd9, 5'd10);
      edge_step();
      check("flush_clears_and_beats_alloc", 64'(rd_busy), 64'd0);

      // write on port 0 completes a producer
      alloc_en = 1'b1; alloc_addr = 5'd4;
      set_ra(5'd4, 5'd9);
      edge_step();
      check("r4_busy_set", 64'(rd_busy), 64'd1);
      we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0BAD;
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      check("r4_busy_pre_edge", 64'(rd_busy), 64'd0);
`else
      check("r4_busy_pre_edge", 64'(rd_busy), 64'd1);
`endif
      edge_step();
      check("r4_busy_cleared", 64'(rd_busy), 64'd0);
      check("r4_data", 64'(rd[31:0]), 64'h0BAD);

      // 6: asynchronous reset between edges
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
      alloc_en = 1'b1; alloc_addr = 5'd12;
      set_ra(5'd3, 5'd12);
      edge_step();
      check("r3_written", 64'(rd[31:0]), 64'h55);
      check("r12_busy", 64'(rd_busy), 64'd2);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_rd", rd, 64'd0);
      check("async_rst_busy", 64'(rd_busy), 64'd0);
      #2;
      rst_n = 1'b1;
      set_ra(5'd4, 5'd7);
      #1;
      check("post_rst_other_regs", rd, 64'd0);
      check("post_rst_conflict", 64'(wr_conflict), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port successor to the single-write 32x32 RegFile. It has NUM_RD asynchronous read ports, two synchronous write ports with fixed priority, and a hard-wired zero register. It adds a per-register busy scoreboard so the pipeline can stall on long-latency producers, and a registered write-conflict flag. It sits in the CPU datapath between decode (reads, allocation) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ra  in  NUM_RD*ADDR_W  read addresses; port k = ra[k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  read data; port k = rd[k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  busy bit of the register addressed by each read port
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
alloc_en  in  1  mark a register as having a pending producer
alloc_addr  in  ADDR_W  register to mark busy
flush  in  1  synchronous clear of all busy bits
wr_conflict  out  1  registered pulse: both ports wrote the same nonzero address last cycle

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, wr_conflict = 0. Reset asserted mid-cycle overrides any write in that cycle.
- Register 0: always reads 0, never busy. Writes and allocs to address 0 are ignored.
- Writes: on the rising clk edge, weN=1 stores wdN at waN. Write latency is 1 edge.
- Same address on both ports (we0 & we1 & wa0==wa1 != 0): port 1 data is stored. wr_conflict = 1 for exactly the following cycle; otherwise wr_conflict = 0.
- Reads: combinational from array state, with no internal clocking. With the optional bypass feature, a read can also see the current cycle's write data.
- Scoreboard, per register, evaluated at the edge:
  - set when alloc_en & alloc_addr==i;
  - cleared when any write enable hits address i;
  - alloc and write to the same address in the same cycle leaves the bit set (new producer wins);
  - flush clears every bit and has priority over alloc in that cycle;
  - writes to data are unaffected by busy state.
- rd_busy[k] = busy[ra_k], combinational. With bypass, it also reads 0 when the same-cycle write targets ra_k and no same-cycle alloc targets it.
- All ports are independent. Any combination of the NUM_RD reads plus 2 writes plus alloc in one cycle is legal.

Optional Feature:
REGFILE_MP_BYPASS_EN
- Defined:
  - Read data is forwarded combinationally. If weN & waN==ra_k & ra_k!=0, rd_k returns wdN (port 1 wins if both match); otherwise it returns array data.
  - rd_busy uses the forwarding rule above.
  - A read in the same cycle as a write returns the new value before the edge.
- Undefined:
  - Reads return pre-edge array contents. The new value is visible the cycle after the write.
  - rd_busy reflects the registered busy bits only.

Test Plan:
1. Reset, then read all addresses on both ports -> every rd = 0, rd_busy = 0, wr_conflict = 0.
2. we0=1, wa0=5, wd0=11; ra0=ra1=5 in the same cycle -> with bypass rd0=rd1=11 immediately; without bypass 0, then 11 after the edge. Next cycle we0=0 -> still 11.
3. we0=we1=1, wa0=wa1=7, wd0=0x1111, wd1=0x2222 -> r7 = 0x2222; wr_conflict = 1 for one cycle, then 0.
4. Write 0xDEADBEEF to r0 and alloc r0 -> r0 reads 0, rd_busy = 0.
5. alloc r9, next cycle ra0=9 -> rd_busy[0]=1. Then we1=1, wa1=9, wd1=42 with alloc r9 in the same cycle -> busy stays 1, r9=42. Then flush -> busy 0.
6. Write 0x55 to r3, then pulse rst_n low for 3 ns between edges -> r3 reads 0 immediately (asynchronous); busy bits cleared.
